jb_predict_unit: RTL and testbench



---
 rtl/jb_predict_if.sv | 25 ++
 rtl/jb_predict_unit.sv | 138 +++++++++++++
 tb/tb_jb_predict_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/jb_predict_if.sv
// Fetch-lookup / resolve-stage bundle for the jump/branch predict unit.
interface jb_predict_if #(parameter int DATA_W = 32);
    logic              f_valid;
    logic [DATA_W-1:0] f_pc;
    logic              f_pred_valid;
    logic              f_pred_taken;
    logic              r_valid;
    logic [3:0]        r_type;
    logic [DATA_W-1:0] r_pc;
    logic              r_pred_taken;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;
    logic [1:0]        jump_sel;
    logic              r_taken;
    logic              mispredict;

    modport master (
        output f_valid, f_pc, r_valid, r_type, r_pc, r_pred_taken, alu_out, alu_zero,
        input  f_pred_valid, f_pred_taken, jump_sel, r_taken, mispredict
    );
    modport slave (
        input  f_valid, f_pc, r_valid, r_type, r_pc, r_pred_taken, alu_out, alu_zero,
        output f_pred_valid, f_pred_taken, jump_sel, r_taken, mispredict
    );
endinterface

// File: rtl/jb_predict_unit.sv
// Branch resolve + 2-bit-counter BHT direction predictor with write-first lookup bypass.
// Optional JB_PREDICT_STATS_EN adds br_count / mp_count statistics outputs.
module jb_predict_unit #(
    parameter int         DATA_W    = 32,
    parameter int         BHT_IDX_W = 6,
    parameter logic [1:0] CTR_INIT  = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    jb_predict_if.slave bus
`ifdef JB_PREDICT_STATS_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] mp_count
`endif
);
    localparam int DEPTH = 1 << BHT_IDX_W;

    localparam logic [3:0] T_J    = 4'b0001;
    localparam logic [3:0] T_JR   = 4'b0010;
    localparam logic [3:0] T_BEQ  = 4'b0011;
    localparam logic [3:0] T_BNE  = 4'b0100;
    localparam logic [3:0] T_BLEZ = 4'b0101;
    localparam logic [3:0] T_BGTZ = 4'b0110;
    localparam logic [3:0] T_BLTZ = 4'b0111;
    localparam logic [3:0] T_BGEZ = 4'b1000;

    logic [DEPTH-1:0][1:0] bht_q, bht_d;
    logic                  f_pred_valid_q, f_pred_valid_d;
    logic                  f_pred_taken_q, f_pred_taken_d;
    logic                  mispredict_q, mispredict_d;

    logic                  lt;
    logic                  is_br;
    logic                  br_taken;
    logic                  upd;
    logic [1:0]            jump_sel;
    logic                  r_taken;
    logic [BHT_IDX_W-1:0]  r_idx, f_idx;
    logic [1:0]            ctr_cur, ctr_new;

    assign lt    = (bus.alu_out == DATA_W'(1));
    assign r_idx = bus.r_pc[BHT_IDX_W+1:2];
    assign f_idx = bus.f_pc[BHT_IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.r_pc[DATA_W-1:BHT_IDX_W+2], bus.r_pc[1:0],
                              bus.f_pc[DATA_W-1:BHT_IDX_W+2], bus.f_pc[1:0]};

    // Resolve decode stays combinational, even during reset.
    always_comb begin
        is_br    = 1'b0;
        br_taken = 1'b0;
        jump_sel = 2'b00;
        r_taken  = 1'b0;
        if (bus.r_valid) begin
            unique case (bus.r_type)
                T_J:     begin jump_sel = 2'b10; r_taken = 1'b1; end
                T_JR:    begin jump_sel = 2'b11; r_taken = 1'b1; end
                T_BEQ:   begin is_br = 1'b1; br_taken = bus.alu_zero;        end
                T_BNE:   begin is_br = 1'b1; br_taken = !bus.alu_zero;       end
                T_BLEZ:  begin is_br = 1'b1; br_taken = lt | bus.alu_zero;   end
                T_BGTZ:  begin is_br = 1'b1; br_taken = !lt & !bus.alu_zero; end
                T_BLTZ:  begin is_br = 1'b1; br_taken = lt;                  end
                T_BGEZ:  begin is_br = 1'b1; br_taken = !lt;                 end
                default: ;
            endcase
            if (is_br) begin
                r_taken  = br_taken;
                jump_sel = br_taken ? 2'b01 : 2'b00;
            end
        end
    end

    assign upd     = is_br & !rst;
    assign ctr_cur = bht_q[r_idx];

    always_comb begin
        ctr_new = ctr_cur;
        if (br_taken) begin
            if (ctr_cur != 2'b11) ctr_new = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_new = ctr_cur - 2'b01;
        end
    end

    // Lookup reads bht_d so a same-index update is visible the same cycle.
    always_comb begin
        bht_d = bht_q;
        if (upd) bht_d[r_idx] = ctr_new;
        f_pred_valid_d = bus.f_valid;
        f_pred_taken_d = bus.f_valid ? bht_d[f_idx][1] : f_pred_taken_q;
        mispredict_d   = upd & (br_taken != bus.r_pred_taken);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bht_q          <= {DEPTH{CTR_INIT}};
            f_pred_valid_q <= 1'b0;
            f_pred_taken_q <= 1'b0;
            mispredict_q   <= 1'b0;
        end else begin
            bht_q          <= bht_d;
            f_pred_valid_q <= f_pred_valid_d;
            f_pred_taken_q <= f_pred_taken_d;
            mispredict_q   <= mispredict_d;
        end
    end

    assign bus.f_pred_valid = f_pred_valid_q;
    assign bus.f_pred_taken = f_pred_taken_q;
    assign bus.mispredict   = mispredict_q;
    assign bus.jump_sel     = jump_sel;
    assign bus.r_taken      = r_taken;

`ifdef JB_PREDICT_STATS_EN
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] mp_count_q, mp_count_d;

    always_comb begin
        br_count_d = br_count_q + {31'd0, upd};
        mp_count_d = mp_count_q + {31'd0, mispredict_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q <= 32'd0;
            mp_count_q <= 32'd0;
        end else begin
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
        end
    end

    assign br_count = br_count_q;
    assign mp_count = mp_count_q;
`endif
endmodule

// File: tb/tb_jb_predict_unit.sv
// Bench for jb_predict_unit: decode table, directed corner sequences, random vs. reference model.
module tb_jb_predict_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jb_predict_if #(.DATA_W(32)) bus ();
`ifdef JB_PREDICT_STATS_EN
    logic [31:0] br_count, mp_count;
`endif

    jb_predict_unit #(.DATA_W(32), .BHT_IDX_W(6), .CTR_INIT(2'b01)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave)
`ifdef JB_PREDICT_STATS_EN
        ,
        .br_count (br_count),
        .mp_count (mp_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: counters as plain ints, 0..3.
    int          bht[64];
    bit          m_pv, m_pt, m_mp;
    int unsigned m_brc, m_mpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_taken(input logic [3:0] ty, input logic [31:0] ao, input logic az);
        bit lt = (ao == 32'd1);
        case (ty)
            4'd3: return az;
            4'd4: return !az;
            4'd5: return lt || az;
            4'd6: return !lt && !az;
            4'd7: return lt;
            4'd8: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit ref_isbr(input logic [3:0] ty);
        return (ty >= 4'd3 && ty <= 4'd8);
    endfunction

    // One cycle: drive, check combinational outputs, clock, update model, check registers.
    task automatic step(input logic fv, input logic [31:0] fpc, input logic rv, input logic [3:0] ty,
                        input logic [31:0] rpc, input logic rpt, input logic [31:0] ao,
                        input logic az, input logic rs);
        bit br, tk, isj;
        logic [1:0] sel;
        bus.f_valid = fv; bus.f_pc = fpc; bus.r_valid = rv; bus.r_type = ty;
        bus.r_pc = rpc; bus.r_pred_taken = rpt; bus.alu_out = ao; bus.alu_zero = az; rst = rs;
        #1;
        br  = rv && ref_isbr(ty);
        tk  = br && ref_taken(ty, ao, az);
        isj = rv && (ty == 4'd1 || ty == 4'd2);
        sel = !rv ? 2'd0 : (ty == 4'd1) ? 2'd2 : (ty == 4'd2) ? 2'd3 : tk ? 2'd1 : 2'd0;
        chk("jump_sel", {30'd0, bus.jump_sel}, {30'd0, sel});
        if (!isj) chk("r_taken", {31'd0, bus.r_taken}, {31'd0, tk});
        @(posedge clk);
        if (rs) begin
            for (int i = 0; i < 64; i++) bht[i] = 1;
            m_pv = 0; m_pt = 0; m_mp = 0; m_brc = 0; m_mpc = 0;
        end else begin
            if (br) begin
                int ri = int'((rpc >> 2) & 32'd63);
                bht[ri] = tk ? ((bht[ri] < 3) ? bht[ri] + 1 : 3) : ((bht[ri] > 0) ? bht[ri] - 1 : 0);
                m_brc++;
            end
            m_pv = fv;
            if (fv) m_pt = (bht[int'((fpc >> 2) & 32'd63)] >= 2);
            m_mp = br && (tk != rpt);
            if (m_mp) m_mpc++;
        end
        #1;
        chk("f_pred_valid", {31'd0, bus.f_pred_valid}, {31'd0, m_pv});
        chk("f_pred_taken", {31'd0, bus.f_pred_taken}, {31'd0, m_pt});
        chk("mispredict",   {31'd0, bus.mispredict},   {31'd0, m_mp});
`ifdef JB_PREDICT_STATS_EN
        chk("br_count", br_count, m_brc);
        chk("mp_count", mp_count, m_mpc);
`endif
    endtask

    typedef struct packed {
        logic        rv;
        logic [3:0]  ty;
        logic [31:0] ao;
        logic        az;
        logic [1:0]  sel;
        logic        tk;
        logic        chk_tk;
    } vec_t;

    function automatic vec_t mk(input logic rv, input logic [3:0] ty, input logic [31:0] ao,
                                input logic az, input logic [1:0] sel, input logic tk, input logic ct);
        vec_t v;
        v.rv = rv; v.ty = ty; v.ao = ao; v.az = az; v.sel = sel; v.tk = tk; v.chk_tk = ct;
        return v;
    endfunction

    vec_t tv[$];

    initial begin
        // Hand-derived decode expectations.
        tv.push_back(mk(0, 4'd3, 32'd0, 1, 2'b00, 0, 1));
        tv.push_back(mk(1, 4'd0, 32'd0, 1, 2'b00, 0, 1));
        tv.push_back(mk(1, 4'd1, 32'd0, 0, 2'b10, 0, 0));
        tv.push_back(mk(1, 4'd2, 32'd0, 0, 2'b11, 0, 0));
        tv.push_back(mk(1, 4'd3, 32'd5, 1, 2'b01, 1, 1));
        tv.push_back(mk(1, 4'd3, 32'd5, 0, 2'b00, 0, 1));
        tv.push_back(mk(1, 4'd4, 32'd5, 0, 2'b01, 1, 1));
        tv.push_back(mk(1, 4'd4, 32'd0, 1, 2'b00, 0, 1));
        tv.push_back(mk(1, 4'd5, 32'd1, 0, 2'b01, 1, 1));
        tv.push_back(mk(1, 4'd5, 32'd0, 0, 2'b00, 0, 1));
        tv.push_back(mk(1, 4'd5, 32'd0, 1, 2'b01, 1, 1));
        tv.push_back(mk(1, 4'd6, 32'd0, 0, 2'b01, 1, 1));
        tv.push_back(mk(1, 4'd6, 32'd1, 0, 2'b00, 0, 1));
        tv.push_back(mk(1, 4'd6, 32'd0, 1, 2'b00, 0, 1));
        tv.push_back(mk(1, 4'd7, 32'd1, 0, 2'b01, 1, 1));
        tv.push_back(mk(1, 4'd7, 32'd2, 0, 2'b00, 0, 1));
        tv.push_back(mk(1, 4'd8, 32'd1, 0, 2'b00, 0, 1));
        tv.push_back(mk(1, 4'd8, 32'hFFFF_FFFF, 0, 2'b01, 1, 1));
        tv.push_back(mk(1, 4'd9, 32'd0, 1, 2'b00, 0, 1));
        tv.push_back(mk(1, 4'd15, 32'd1, 1, 2'b00, 0, 1));

        // Reset state.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_pred_valid", {31'd0, bus.f_pred_valid}, 0);
        chk("rst_mispredict", {31'd0, bus.mispredict}, 0);

        // Decode table, held in reset so the BHT is untouched.
        for (int i = 0; i < tv.size(); i++) begin
            bus.f_valid = 0; bus.r_valid = tv[i].rv; bus.r_type = tv[i].ty;
            bus.alu_out = tv[i].ao; bus.alu_zero = tv[i].az; bus.r_pc = 32'h40;
            bus.r_pred_taken = 0; rst = 1;
            #1;
            chk($sformatf("tbl%0d_sel", i), {30'd0, bus.jump_sel}, {30'd0, tv[i].sel});
            if (tv[i].chk_tk) chk($sformatf("tbl%0d_tk", i), {31'd0, bus.r_taken}, {31'd0, tv[i].tk});
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // First lookup after reset: weakly not-taken.
        step(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        chk("first_lookup_valid", {31'd0, bus.f_pred_valid}, 1);
        chk("first_lookup_taken", {31'd0, bus.f_pred_taken}, 0);

        // Two taken BEQs at 0x40 saturate the counter upward.
        step(0, 0, 1, 4'd3, 32'h40, 0, 0, 1, 0);
        chk("beq1_mispredict", {31'd0, bus.mispredict}, 1);
        step(0, 0, 1, 4'd3, 32'h40, 0, 0, 1, 0);
        step(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        chk("beq_lookup_taken", {31'd0, bus.f_pred_taken}, 1);
        chk("bht40_model", bht[16], 3);

        // Jumps: no mispredict, BHT unchanged.
        step(0, 0, 1, 4'd1, 32'h40, 0, 0, 0, 0);
        chk("j_no_mp", {31'd0, bus.mispredict}, 0);
        step(0, 0, 1, 4'd2, 32'h40, 0, 0, 1, 0);
        chk("jr_no_mp", {31'd0, bus.mispredict}, 0);
        step(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        chk("jump_bht_kept", {31'd0, bus.f_pred_taken}, 1);

        // f_valid low holds f_pred_taken.
        step(0, 32'h80, 0, 0, 0, 0, 0, 0, 0);
        chk("hold_valid", {31'd0, bus.f_pred_valid}, 0);
        chk("hold_taken", {31'd0, bus.f_pred_taken}, 1);

        // Same-cycle lookup/update at 0x80 (counter 01, taken): bypass gives 1.
        step(1, 32'h80, 1, 4'd3, 32'h80, 0, 0, 1, 0);
        chk("bypass_taken", {31'd0, bus.f_pred_taken}, 1);

        // Different indices in the same cycle.
        step(1, 32'h84, 1, 4'd4, 32'h40, 1, 0, 1, 0);
        chk("diff_idx_taken", {31'd0, bus.f_pred_taken}, 0);

        // Mispredicting branch, then reset the cycle after: pulse discarded.
        step(0, 0, 1, 4'd4, 32'h40, 1, 0, 1, 0);
        chk("pre_rst_mp", {31'd0, bus.mispredict}, 1);
        step(0, 0, 1, 4'd4, 32'h40, 1, 0, 1, 1);
        chk("rst_kills_mp", {31'd0, bus.mispredict}, 0);
`ifdef JB_PREDICT_STATS_EN
        chk("rst_br_count", br_count, 0);
        chk("rst_mp_count", mp_count, 0);
`endif
        // A single taken branch now lifts 01 to 10 only if reset restored CTR_INIT.
        step(1, 32'h80, 1, 4'd3, 32'h40, 0, 0, 1, 0);
        chk("post_rst_80", {31'd0, bus.f_pred_taken}, 0);
        step(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_40", {31'd0, bus.f_pred_taken}, 1);

        // Random traffic against the model, few indices to force aliasing and bypass.
        for (int c = 0; c < 600; c++) begin
            logic [31:0] fpc, rpc, ao;
            logic [3:0]  ty;
            int          sel_ao;
            fpc = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            rpc = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            ty  = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(3, 8)) : 4'($urandom_range(0, 15));
            sel_ao = $urandom_range(0, 4);
            ao = (sel_ao == 0) ? 32'd0 : (sel_ao == 1) ? 32'd1 : (sel_ao == 2) ? 32'hFFFF_FFFF :
                 (sel_ao == 3) ? 32'd2 : $urandom();
            step(1'($urandom_range(0, 1)), fpc, 1'($urandom_range(0, 3) != 0), ty, rpc,
                 1'($urandom_range(0, 1)), ao, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 59) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
